// File: rtl/rob_sn_issuer_if.sv
// Handshake bundle between dispatch, execution units, the ROB and the SN issuer.
interface rob_sn_issuer_if #(
  parameter int unsigned p_depth    = 32,
  parameter int unsigned p_ptrwidth = $clog2(p_depth),
  parameter int unsigned p_bitwidth = 32
);
  // Dispatch-side allocation
  logic                  alloc_val;
  logic                  alloc_rdy;
  logic [p_ptrwidth-1:0] alloc_sn;
  // Execution-unit completions
  logic                  cpl_val;
  logic                  cpl_rdy;
  logic [p_ptrwidth-1:0] cpl_sn;
  logic [p_bitwidth-1:0] cpl_data;
  // ROB insert port
  logic                  ins_en;
  logic                  ins_cpl;
  logic [p_ptrwidth-1:0] ins_sn_in;
  logic [p_bitwidth-1:0] ins_data_in;
  // ROB head dequeue stream
  logic                  deq_front_cpl;
  logic [p_bitwidth-1:0] deq_front_data;
  // Retirement and status
  logic                  retire_val;
  logic [p_ptrwidth-1:0] retire_sn;
  logic [p_bitwidth-1:0] retire_data;
  logic [p_ptrwidth:0]   occupancy;
  logic                  err;

  // Environment side: dispatch, execution units and ROB
  modport master (
    output alloc_val, cpl_val, cpl_sn, cpl_data, ins_cpl, deq_front_cpl, deq_front_data,
    input  alloc_rdy, alloc_sn, cpl_rdy, ins_en, ins_sn_in, ins_data_in,
    input  retire_val, retire_sn, retire_data, occupancy, err
  );

  // Issuer side
  modport slave (
    input  alloc_val, cpl_val, cpl_sn, cpl_data, ins_cpl, deq_front_cpl, deq_front_data,
    output alloc_rdy, alloc_sn, cpl_rdy, ins_en, ins_sn_in, ins_data_in,
    output retire_val, retire_sn, retire_data, occupancy, err
  );
endinterface

// File: rtl/rob_sn_issuer.sv
// ROB sequence-number issuer: in-order SN allocation, completion forwarding
// to the ROB insert port, and retirement from the ROB head dequeue stream.
module rob_sn_issuer #(
  parameter int unsigned p_depth    = 32,
  parameter int unsigned p_ptrwidth = $clog2(p_depth),
  parameter int unsigned p_bitwidth = 32
) (
  input  logic           clk,
  input  logic           rst,
  rob_sn_issuer_if.slave bus
);

  localparam int unsigned            occ_w    = p_ptrwidth + 1;
  localparam logic [occ_w-1:0]       occ_full = occ_w'(p_depth);
  localparam logic [occ_w-1:0]       occ_one  = occ_w'(1);
  localparam logic [p_ptrwidth-1:0]  ptr_one  = p_ptrwidth'(1);

  typedef enum logic {IDLE, DRIVE} state_t;

  state_t                state;
  logic [p_ptrwidth-1:0] alloc_ptr;
  logic [p_ptrwidth-1:0] retire_ptr;
  logic [occ_w-1:0]      occ;
  logic [p_depth-1:0]    outstanding;
  logic [p_depth-1:0]    completed;

  logic                  ins_en_q;
  logic                  cpl_rdy_q;
  logic [p_ptrwidth-1:0] ins_sn_q;
  logic [p_bitwidth-1:0] ins_data_q;
  logic                  retire_val_q;
  logic [p_ptrwidth-1:0] retire_sn_q;
  logic [p_bitwidth-1:0] retire_data_q;
  logic                  err_q;

  logic alloc_rdy_c;
  logic alloc_fire;
  logic retire_fire;
  logic cpl_take;
  logic cpl_legal;
  logic cpl_accept;

  // Handshake qualifiers; a completion racing its own retirement is never legal
  assign alloc_rdy_c = (occ != occ_full);
  assign alloc_fire  = bus.alloc_val && alloc_rdy_c;
  assign retire_fire = bus.deq_front_cpl && (occ != '0);
  assign cpl_take    = bus.cpl_val && (state == IDLE);
  assign cpl_legal   = outstanding[bus.cpl_sn] && !completed[bus.cpl_sn] &&
                       !(retire_fire && (bus.cpl_sn == retire_ptr));
  assign cpl_accept  = cpl_take && cpl_legal;

  // Pointers, occupancy and the outstanding/completed scoreboards
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alloc_ptr   <= '0;
      retire_ptr  <= '0;
      occ         <= '0;
      outstanding <= '0;
      completed   <= '0;
    end else begin
      if (alloc_fire) begin
        outstanding[alloc_ptr] <= 1'b1;
        alloc_ptr              <= alloc_ptr + ptr_one;
      end
      if (cpl_accept) begin
        completed[bus.cpl_sn] <= 1'b1;
      end
      if (retire_fire) begin
        outstanding[retire_ptr] <= 1'b0;
        completed[retire_ptr]   <= 1'b0;
        retire_ptr              <= retire_ptr + ptr_one;
      end
      if (alloc_fire && !retire_fire) begin
        occ <= occ + occ_one;
      end else if (!alloc_fire && retire_fire) begin
        occ <= occ - occ_one;
      end
    end
  end

  // Insert FSM: capture a completion in IDLE, hold it on the ROB port until acknowledged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ins_en_q   <= 1'b0;
      cpl_rdy_q  <= 1'b1;
      ins_sn_q   <= '0;
      ins_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpl_val) begin
            ins_sn_q   <= bus.cpl_sn;
            ins_data_q <= bus.cpl_data;
            if (cpl_legal) begin
              state     <= DRIVE;
              ins_en_q  <= 1'b1;
              cpl_rdy_q <= 1'b0;
            end
          end
        end
        DRIVE: begin
          if (bus.ins_cpl) begin
            state     <= IDLE;
            ins_en_q  <= 1'b0;
            cpl_rdy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Retirement report one cycle after the head dequeue, plus sticky protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_val_q  <= 1'b0;
      retire_sn_q   <= '0;
      retire_data_q <= '0;
      err_q         <= 1'b0;
    end else begin
      retire_val_q <= retire_fire;
      if (retire_fire) begin
        retire_sn_q   <= retire_ptr;
        retire_data_q <= bus.deq_front_data;
      end
      if ((cpl_take && !cpl_legal) || (bus.deq_front_cpl && !retire_fire)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.alloc_rdy   = alloc_rdy_c;
  assign bus.alloc_sn    = alloc_ptr;
  assign bus.cpl_rdy     = cpl_rdy_q;
  assign bus.ins_en      = ins_en_q;
  assign bus.ins_sn_in   = ins_sn_q;
  assign bus.ins_data_in = ins_data_q;
  assign bus.retire_val  = retire_val_q;
  assign bus.retire_sn   = retire_sn_q;
  assign bus.retire_data = retire_data_q;
  assign bus.occupancy   = occ;
  assign bus.err         = err_q;

endmodule

// File: doc/rob_sn_issuer.md
Name: rob_sn_issuer

Overview:
- Dispatch/commit-side partner of rob_OpCentricQueue.
- Allocates reorder-buffer sequence numbers (SNs) in program order and forwards out-of-order completions from execution units to the ROB insert port.
- Drives the ins_en/ins_cpl handshake and consumes the ROB head dequeue stream to retire entries and free SNs.
- Sits between the dispatch stage, execution units and the ROB.

Parameters:
- p_depth, 32, number of ROB entries; power of two, >= 2.
- p_ptrwidth, $clog2(p_depth), SN width.
- p_bitwidth, 32, payload width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- alloc_val  in  1  dispatch requests an SN
- alloc_rdy  out  1  SN available (not full)
- alloc_sn  out  p_ptrwidth  SN granted on alloc_val&&alloc_rdy
- cpl_val  in  1  execution unit presents completion
- cpl_rdy  out  1  completion accepted this cycle
- cpl_sn  in  p_ptrwidth  SN of completing op
- cpl_data  in  p_bitwidth  result payload
- ins_en  out  1  insert request to ROB
- ins_cpl  in  1  ROB insert acknowledge
- ins_sn_in  out  p_ptrwidth  SN to ROB
- ins_data_in  out  p_bitwidth  payload to ROB
- deq_front_cpl  in  1  ROB head completed and dequeued this cycle
- deq_front_data  in  p_bitwidth  ROB head payload
- retire_val  out  1  one op retired
- retire_sn  out  p_ptrwidth  retired SN
- retire_data  out  p_bitwidth  retired payload
- occupancy  out  p_ptrwidth+1  allocated, not yet retired
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst=0, async):
  - alloc_ptr=0, retire_ptr=0, occupancy=0.
  - outstanding/completed bitmaps cleared.
  - FSM=IDLE; ins_en=0, ins_sn_in=0, ins_data_in=0.
  - retire_val=0, retire_sn=0, retire_data=0, err=0.
  - Reset mid-handshake abandons the insert; the ROB is reset alongside.
- Allocation:
  - alloc_sn=alloc_ptr combinationally; alloc_rdy = (occupancy != p_depth).
  - On fire: set outstanding[alloc_ptr], alloc_ptr += 1 mod p_depth.
- Insert FSM, states IDLE and DRIVE:
  - IDLE: cpl_rdy=1, ins_en=0. On cpl_val, register cpl_sn/cpl_data into ins_sn_in/ins_data_in.
    - Legal completion (outstanding[cpl_sn]=1 and completed[cpl_sn]=0): set completed[cpl_sn], next state DRIVE.
    - Illegal completion: drop it, set err, stay in IDLE.
  - DRIVE: ins_en=1, cpl_rdy=0, ins_sn_in/ins_data_in held stable.
    - ins_cpl sampled 1 at posedge: next IDLE, ins_en low the following cycle.
    - ins_cpl=0: stay in DRIVE indefinitely.
  - Latency: completion to ins_en high = 1 cycle; minimum 2 cycles per insert.
- Retirement:
  - deq_front_cpl=1 at posedge with occupancy>0:
    - clear outstanding and completed bits at retire_ptr;
    - retire_ptr += 1 mod p_depth;
    - next cycle: retire_val=1, retire_sn = old retire_ptr, retire_data = deq_front_data.
    - One retirement per cycle maximum; back-to-back dequeues are supported.
  - deq_front_cpl=1 with occupancy=0: set err, no state change.
- Occupancy:
  - +1 on alloc fire, −1 on retire; both in the same cycle leaves it unchanged.
  - When full, a same-cycle retire does not make alloc_rdy high in that cycle; alloc_rdy depends on registered occupancy only.
- Wrap: pointers wrap p_depth−1 → 0 with no special case.
- Completion for an SN being retired in the same cycle is illegal (it is not yet completed) and sets err.

Test Plan:
- Reset then 8 allocs with p_depth=8 -> alloc_sn 0..7, occupancy=8, alloc_rdy=0; 9th alloc_val is not granted.
- Full ROB, completions issued in SN order 7,6,...,0 with ins_cpl delayed 3 cycles each -> ins_en held 3 cycles per insert with stable sn/data; cpl_rdy=0 throughout DRIVE.
- After the completion of SN 0, drive deq_front_cpl for 8 consecutive cycles with data A0..A7 -> retire_val 8 cycles, retire_sn 0..7, retire_data A0..A7, occupancy returns to 0.
- Alloc and retire in the same cycle while occupancy=5 -> occupancy stays 5; alloc_ptr wraps 7→0 correctly across 20 ops.
- Completion for unallocated SN 3, and a duplicate completion for SN 1 -> err=1, no ins_en pulse; err stays 1 until reset.
- Assert rst low while in DRIVE -> ins_en=0 immediately, occupancy=0, alloc_sn=0 after release.
